// File: rtl/topk_tracker_if.sv
// topk_tracker_if: sample/read bus for topk_tracker.
//   master drives : din_valid, din, clear, rank_sel
//   slave  drives : dout, dout_valid, count
// Widths follow DATA_WIDTH and K; keep them equal to the tracker's own parameters.
interface topk_tracker_if #(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 4
);
    localparam int RW = $clog2(K);
    localparam int CW = $clog2(K + 1);

    logic                  din_valid;
    logic [DATA_WIDTH-1:0] din;
    logic                  clear;
    logic [RW-1:0]         rank_sel;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic [CW-1:0]         count;

    modport master (
        output din_valid, din, clear, rank_sel,
        input  dout, dout_valid, count
    );

    modport slave (
        input  din_valid, din, clear, rank_sel,
        output dout, dout_valid, count
    );
endinterface

// File: rtl/topk_tracker.sv
// topk_tracker: keeps the K largest samples seen since reset/clear in a
// sorted register file (top[0] largest) and reads any rank combinationally.
// Ports:
//   clk      - clock, state changes on rising edge
//   resetn   - synchronous active-low reset (same effect as clear)
//   bus      - topk_tracker_if.slave: din_valid/din sample in, clear flush,
//              rank_sel read select, dout/dout_valid read data, count occupancy
module topk_tracker #(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 4,
    parameter bit SIGNED     = 1'b0,
    parameter bit UNIQUE     = 1'b0
) (
    input  logic           clk,
    input  logic           resetn,
    topk_tracker_if.slave  bus
);
    localparam int RW = $clog2(K);
    localparam int CW = $clog2(K + 1);

    logic [K-1:0][DATA_WIDTH-1:0] top, nxt;
    logic [CW-1:0]                count;
    logic [K-1:0]                 occ, gt, eq, ins;
    logic                         dup, accept;
    logic [DATA_WIDTH-1:0]        rd_val;

    // ins[i]: din belongs at or above slot i. The table is sorted and
    // occupancy is contiguous from slot 0, so ins is monotone (once set,
    // set for every higher index); the first set bit is the insert point.
    for (genvar i = 0; i < K; i++) begin : g_slot
        assign occ[i] = CW'(i) < count;
        if (SIGNED) begin : g_sgn
            assign gt[i] = $signed(bus.din) > $signed(top[i]);
        end else begin : g_uns
            assign gt[i] = bus.din > top[i];
        end
        assign eq[i]  = occ[i] && (bus.din == top[i]);
        assign ins[i] = !occ[i] || gt[i];
        if (i == 0) begin : g_head
            assign nxt[i] = ins[i] ? bus.din : top[i];
        end else begin : g_body
            // below the insert point: shift down; at it: din; above: hold
            assign nxt[i] = ins[i-1] ? top[i-1] : (ins[i] ? bus.din : top[i]);
        end
    end

    assign dup    = UNIQUE && (|eq);
    // ins[K-1] clear means the table is full and din <= top[K-1]
    assign accept = bus.din_valid && !dup && ins[K-1];

    always_ff @(posedge clk) begin
        if (!resetn || bus.clear) begin
            top   <= '0;
            count <= '0;
        end else if (accept) begin
            top <= nxt;
            if (count != CW'(K))
                count <= count + CW'(1);
        end
    end

    // explicit mux keeps out-of-range rank_sel (non-power-of-2 K) safe
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < K; i++)
            if (bus.rank_sel == RW'(i))
                rd_val = top[i];
    end

    assign bus.dout_valid = CW'(bus.rank_sel) < count;
    assign bus.dout       = bus.dout_valid ? rd_val : '0;
    assign bus.count      = count;
endmodule

// File: tb/tb_topk_tracker.sv
module tb_topk_tracker;
    logic       clk;
    logic       v_b, clr_b, rst_b;
    logic [7:0] d_b;
    logic [1:0] rs;
    bit         chk_en;
    int         checks, errors;

    // model: one sorted (descending) queue per DUT variant
    // 0: unsigned dup  1: unsigned unique  2: signed dup  3: unsigned dup K=3
    logic [7:0] mq[4][$];
    logic [7:0] dd[4];
    logic       dv[4];
    int         cn[4];

    topk_tracker_if #(.DATA_WIDTH(8), .K(4)) if0 ();
    topk_tracker_if #(.DATA_WIDTH(8), .K(4)) if1 ();
    topk_tracker_if #(.DATA_WIDTH(8), .K(4)) if2 ();
    topk_tracker_if #(.DATA_WIDTH(8), .K(3)) if3 ();

    topk_tracker #(.DATA_WIDTH(8), .K(4), .SIGNED(1'b0), .UNIQUE(1'b0)) u0 (.clk(clk), .resetn(rst_b), .bus(if0));
    topk_tracker #(.DATA_WIDTH(8), .K(4), .SIGNED(1'b0), .UNIQUE(1'b1)) u1 (.clk(clk), .resetn(rst_b), .bus(if1));
    topk_tracker #(.DATA_WIDTH(8), .K(4), .SIGNED(1'b1), .UNIQUE(1'b0)) u2 (.clk(clk), .resetn(rst_b), .bus(if2));
    topk_tracker #(.DATA_WIDTH(8), .K(3), .SIGNED(1'b0), .UNIQUE(1'b0)) u3 (.clk(clk), .resetn(rst_b), .bus(if3));

    assign if0.din_valid = v_b; assign if0.din = d_b; assign if0.clear = clr_b; assign if0.rank_sel = rs;
    assign if1.din_valid = v_b; assign if1.din = d_b; assign if1.clear = clr_b; assign if1.rank_sel = rs;
    assign if2.din_valid = v_b; assign if2.din = d_b; assign if2.clear = clr_b; assign if2.rank_sel = rs;
    assign if3.din_valid = v_b; assign if3.din = d_b; assign if3.clear = clr_b; assign if3.rank_sel = rs;

    assign dd[0] = if0.dout; assign dv[0] = if0.dout_valid; assign cn[0] = 32'(if0.count);
    assign dd[1] = if1.dout; assign dv[1] = if1.dout_valid; assign cn[1] = 32'(if1.count);
    assign dd[2] = if2.dout; assign dv[2] = if2.dout_valid; assign cn[2] = 32'(if2.count);
    assign dd[3] = if3.dout; assign dv[3] = if3.dout_valid; assign cn[3] = 32'(if3.count);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int kk(int m);
        return (m == 3) ? 3 : 4;
    endfunction

    function automatic int key(int m, logic [7:0] v);
        if (m == 2) return int'($signed(v));
        return int'({24'b0, v});
    endfunction

    function automatic int mval(int m, int r);
        if (r < mq[m].size()) return int'(mq[m][r]);
        return 0;
    endfunction

    // apply the current inputs to the model as the DUT would at this edge
    task automatic mupd();
        for (int m = 0; m < 4; m++) begin
            if (!rst_b || clr_b) begin
                mq[m].delete();
            end else if (v_b) begin
                bit drop = 1'b0;
                int pos;
                if (m == 1)
                    for (int j = 0; j < mq[m].size(); j++)
                        if (mq[m][j] == d_b) drop = 1'b1;
                if (!drop) begin
                    pos = mq[m].size();
                    for (int j = mq[m].size() - 1; j >= 0; j--)
                        if (key(m, d_b) > key(m, mq[m][j])) pos = j;
                    if (pos < kk(m)) begin
                        mq[m].insert(pos, d_b);
                        if (mq[m].size() > kk(m)) void'(mq[m].pop_back());
                    end
                end
            end
        end
    endtask

    // one clock with the given inputs, then inputs return to idle
    task automatic cyc(input bit v, input logic [7:0] d, input bit clr, input bit rst);
        v_b = v; d_b = d; clr_b = clr; rst_b = rst;
        @(posedge clk);
        mupd();
        #1;
        v_b = 1'b0; clr_b = 1'b0; rst_b = 1'b1;
    endtask

    task automatic rdk(input string nm, input int m, input int r, input int ed, input bit ev);
        rs = r[1:0];
        @(negedge clk); #1;
        checks++;
        if (dd[m] !== ed[7:0] || dv[m] !== ev) begin
            errors++;
            $display("FAIL %s: dut%0d rank%0d dout=%0d valid=%0b, expected dout=%0d valid=%0b",
                     nm, m, r, dd[m], dv[m], ed, ev);
        end
        checks++;
        if (mval(m, r) != ed || ((r < mq[m].size()) != ev)) begin
            errors++;
            $display("FAIL %s_model: model%0d rank%0d value=%0d, expected %0d", nm, m, r, mval(m, r), ed);
        end
        @(posedge clk); #1;
    endtask

    task automatic cnt(input string nm, input int m, input int ec);
        @(negedge clk); #1;
        checks++;
        if (cn[m] != ec) begin
            errors++;
            $display("FAIL %s: dut%0d count=%0d, expected %0d", nm, m, cn[m], ec);
        end
        checks++;
        if (mq[m].size() != ec) begin
            errors++;
            $display("FAIL %s_model: model%0d count=%0d, expected %0d", nm, m, mq[m].size(), ec);
        end
        @(posedge clk); #1;
    endtask

    // every cycle: all four DUTs against the model at the current rank_sel
    always @(negedge clk) begin
        if (chk_en) begin
            for (int m = 0; m < 4; m++) begin
                int r;
                logic [7:0] ev8;
                bit evld;
                r = int'(rs);
                evld = r < mq[m].size();
                ev8 = evld ? mq[m][r] : 8'h00;
                checks++;
                if (cn[m] != mq[m].size() || dd[m] !== ev8 || dv[m] !== evld) begin
                    errors++;
                    $display("FAIL cmp: dut%0d rank%0d count=%0d dout=%0d valid=%0b, expected count=%0d dout=%0d valid=%0b",
                             m, r, cn[m], dd[m], dv[m], mq[m].size(), ev8, evld);
                end
            end
        end
    end

    initial begin
        checks = 0; errors = 0; chk_en = 1'b0;
        v_b = 1'b0; d_b = 8'h00; clr_b = 1'b0; rst_b = 1'b0; rs = 2'd0;

        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk_en = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cnt("reset_count", 0, 0);
        rdk("reset_r0", 0, 0, 0, 1'b0);

        // basic stream
        cyc(1'b1, 8'd5, 1'b0, 1'b1); cyc(1'b1, 8'd9, 1'b0, 1'b1); cyc(1'b1, 8'd3, 1'b0, 1'b1);
        cyc(1'b1, 8'd7, 1'b0, 1'b1); cyc(1'b1, 8'd1, 1'b0, 1'b1);
        cnt("stream_count", 0, 4);
        rdk("stream_r0", 0, 0, 9, 1'b1);
        rdk("stream_r1", 0, 1, 7, 1'b1);
        rdk("stream_r2", 0, 2, 5, 1'b1);
        rdk("stream_r3", 0, 3, 3, 1'b1);
        cnt("k3_count", 3, 3);
        rdk("k3_r2", 3, 2, 5, 1'b1);
        rdk("k3_r3_oob", 3, 3, 0, 1'b0);

        // full table: below-min dropped, mid value shifts tail out
        cyc(1'b1, 8'd2, 1'b0, 1'b1);
        rdk("full_drop_r3", 0, 3, 3, 1'b1);
        cyc(1'b1, 8'd6, 1'b0, 1'b1);
        rdk("full_ins_r2", 0, 2, 6, 1'b1);
        rdk("full_ins_r3", 0, 3, 5, 1'b1);

        // duplicates
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b1, 8'd8, 1'b0, 1'b1); cyc(1'b1, 8'd8, 1'b0, 1'b1); cyc(1'b1, 8'd8, 1'b0, 1'b1);
        cnt("dup_count", 0, 3);
        rdk("dup_r2", 0, 2, 8, 1'b1);
        rdk("dup_r3", 0, 3, 0, 1'b0);
        cnt("uniq_count", 1, 1);
        rdk("uniq_r1", 1, 1, 0, 1'b0);

        // signed vs unsigned
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b1, 8'hFF, 1'b0, 1'b1); cyc(1'b1, 8'h02, 1'b0, 1'b1);
        rdk("uns_r0", 0, 0, 255, 1'b1);
        rdk("uns_r1", 0, 1, 2, 1'b1);
        rdk("sgn_r0", 2, 0, 2, 1'b1);
        rdk("sgn_r1", 2, 1, 255, 1'b1);

        // empty vs stored zero
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b1, 8'h00, 1'b0, 1'b1);
        cnt("zero_count", 0, 1);
        rdk("zero_r0", 0, 0, 0, 1'b1);
        cyc(1'b0, 8'h10, 1'b0, 1'b1);
        cnt("novalid_count", 0, 1);
        rdk("novalid_r1", 0, 1, 0, 1'b0);

        // clear beats din_valid
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b1, 8'd9, 1'b0, 1'b1); cyc(1'b1, 8'd7, 1'b0, 1'b1);
        cyc(1'b1, 8'd5, 1'b0, 1'b1); cyc(1'b1, 8'd3, 1'b0, 1'b1);
        cyc(1'b1, 8'hAA, 1'b1, 1'b1);
        cnt("clr_coll_count", 0, 0);
        cyc(1'b1, 8'd4, 1'b0, 1'b1);
        rdk("clr_after_r0", 0, 0, 4, 1'b1);
        cnt("clr_after_count", 0, 1);

        // reset mid-stream
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b1, 8'd9, 1'b0, 1'b1); cyc(1'b1, 8'd7, 1'b0, 1'b1);
        cyc(1'b1, 8'h20, 1'b0, 1'b0);
        cnt("rst_mid_count", 0, 0);
        rdk("rst_mid_r0", 0, 0, 0, 1'b0);
        rdk("rst_mid_r1", 0, 1, 0, 1'b0);
        cyc(1'b1, 8'd6, 1'b0, 1'b1);
        rdk("rst_after_r0", 0, 0, 6, 1'b1);

        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/topk_tracker.md
# topk_tracker

Streaming top-K tracker: keeps the K largest samples seen since the last reset or clear in a sorted register file, and returns the value at any rank on a registered-state read port. This is the parametrised successor of the team's fixed largest/second-largest tracker. It adds K-deep ranking, input valid qualification, signed/unsigned compare, duplicate suppression, explicit empty-slot tracking and a synchronous clear. It sits on sample streams (statistics, peak detection) ahead of software-visible status registers.

## Interface
- DATA_WIDTH, 32, sample width in bits (>=1)
- K, 4, number of ranked entries kept (>=2)
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned
- UNIQUE, 0, 1 = drop a sample equal to any occupied entry; 0 = keep duplicates
- clk  in  1  clock; all state changes on rising edge
- resetn  in  1  synchronous, active-low reset
- din_valid  in  1  din is sampled this cycle when high
- din  in  DATA_WIDTH  sample
- clear  in  1  synchronous flush of all entries
- rank_sel  in  $clog2(K)  rank to read (0 = largest)
- dout  out  DATA_WIDTH  value at rank_sel, 0 if that slot is empty
- dout_valid  out  1  high when rank_sel < count
- count  out  $clog2(K+1)  occupied entries, saturates at K

## Operation
- State: entries top[0..K-1] with top[0] largest, non-increasing order; per-slot occupancy given by count (slots 0..count-1 occupied). Unoccupied slots hold 0.
- Reset (resetn=0) and clear=1 behave identically: all entries 0, count 0. resetn has priority over clear, and clear has priority over din_valid. A sample presented with clear is discarded.
- Accepted sample (din_valid=1, not cleared, not dropped): insertion position p = lowest index i such that slot i is empty or din > top[i] (strict). Slots p..K-2 shift down one (top[i+1] <= top[i]), top[p] <= din, and top[K-1] is discarded when full. If no such p exists (full table, din <= top[K-1]), state is unchanged.
- Strict compare means that, with UNIQUE=0, an equal value is placed after existing equals and duplicates occupy separate ranks.
- UNIQUE=1: if din equals any occupied entry, the sample is dropped and state is unchanged.
- count increments on each accepted insert while count < K, and holds at K.
- Compare uses $signed when SIGNED=1 and unsigned otherwise. There is no width growth or arithmetic.
- Empty slots are distinct from stored zeros. A sample 0 into an empty table occupies slot 0.
- Read port is combinational from registered state: dout = top[rank_sel] when rank_sel < count, else 0. dout_valid = (rank_sel < count). rank_sel >= K (non-power-of-2 K) gives dout 0 and dout_valid 0.
- There is no output backpressure and the block accepts one sample every cycle.

## Timing
- Insert latency 1 cycle: a sample accepted at edge n is visible on dout/count after edge n, i.e. in cycle n+1.
- clear/reset take effect at the edge they are sampled: count=0, dout=0, dout_valid=0 from the next cycle.
- Reset values: every top[i]=0, count=0, dout=0, dout_valid=0.
- A change in rank_sel reflects on dout/dout_valid in the same cycle. These are combinational outputs with no edge needed.
- Reset mid-stream: prior contents are lost. The first sample after resetn rises is accepted normally.
- Full-rate back-to-back samples are required. The compare-and-shift for all K slots is done in a single cycle.

## Test plan
- DATA_WIDTH=8, K=4: reset, then stream 5,9,3,7,1 on consecutive cycles -> top=9,7,5,3; count=4; rank_sel=1 gives dout=7; rank_sel=3 gives 3 with dout_valid=1.
- UNIQUE=0: stream 8,8,8 -> count=3, ranks 0-2 read 8, rank 3 gives dout=0 and dout_valid=0. UNIQUE=1 with the same stream -> count=1, rank 1 gives dout_valid=0.
- SIGNED=1: stream 0xFF,0x02 -> rank0=0x02, rank1=0xFF. SIGNED=0 with the same stream -> rank0=0xFF, rank1=0x02.
- Empty vs zero: after reset, din=0 with din_valid=1 -> count=1, rank0 gives dout=0 and dout_valid=1. din=0x10 with din_valid=0 -> no change.
- Clear collision: table holds 9,7,5,3; clear=1 with din_valid=1 and din=0xAA in the same cycle -> count=0 next cycle. Then din=4 -> rank0=4, count=1.
- Reset mid-stream: table holds 9,7 and resetn=0 is asserted while din_valid=1 and din=0x20 -> count=0 and all ranks read 0. After release, din=6 -> rank0=6.
